// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl_pkg
// Description : Shared types and default sizes for the shift round-robin
//               sequencer (state encoding, requester id, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    // Default operand width and shift-amount width
    localparam int DEF_WIDTH = 4;
    localparam int DEF_SHW   = 2;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Requester identifier (two requesters)
    typedef logic req_id_t;

endpackage : shift_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. The pointer names the
//               requester that wins a tie; it moves to the loser on accept.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant: single requester wins outright, a tie goes to the pointer holder
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    // Next pointer: after requester 0 is served requester 1 gets priority
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[0];
        end
    end

    // Pointer register, requester 0 holds priority out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/shift_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_rr_sequencer
// Description : One iterative left-shift engine (one bit per cycle) shared by
//               two requesters through a round-robin arbiter. Results leave on
//               a valid/ready channel with requester id and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rr_sequencer
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_ovf,
    output logic             busy
);

    localparam logic [SHW-1:0] C_CNT_ONE = SHW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    req_id_t          id_q,    id_d;
    logic             ovf_q,   ovf_d;

    logic [1:0]       grant;
    logic             in_idle;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_shamt;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = in_idle && (grant != 2'b00);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  ({req1_valid, req0_valid}),
        .enable_i (in_idle),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Operand mux for the granted requester; only meaningful on accept
    always_comb begin
        sel_data  = req0_data;
        sel_shamt = req0_shamt;
        if (grant[1]) begin
            sel_data  = req1_data;
            sel_shamt = req1_shamt;
        end
    end

    // FSM and shift datapath next-state logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = sel_data;
                    cnt_d   = sel_shamt;
                    id_d    = grant[1];
                    ovf_d   = 1'b0;
                    state_d = (sel_shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                ovf_d = ovf_q | acc_q[WIDTH-1];
                acc_d = {acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result channel reads zero outside DONE so idle outputs are quiet
    assign res_valid  = (state_q == ST_DONE);
    assign res_data   = res_valid ? acc_q : '0;
    assign res_id     = res_valid & id_q;
    assign res_ovf    = res_valid & ovf_q;
    assign busy       = ~in_idle;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

endmodule : shift_rr_sequencer
`default_nettype wire

// File: tb/tb_shift_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rr_sequencer
// Description : Self-checking bench for shift_rr_sequencer with directed
//               scenarios and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rr_sequencer;

    localparam int WIDTH = 4;
    localparam int SHW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data, res_data;
    logic [SHW-1:0]   req0_shamt, req1_shamt;
    logic             res_valid, res_ready, res_id, res_ovf, busy;

    int errors = 0;
    int checks = 0;

    shift_rr_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: engine is free, counting down, or holding a result
    int               m_phase;   // 0 free, 1 working, 2 result held
    int               m_left;
    logic             m_ptr;
    logic [WIDTH-1:0] m_data;
    logic             m_id;
    logic             m_ovf;

    function automatic logic m_rdy0();
        return (m_phase == 0) && req0_valid && (!req1_valid || (m_ptr == 1'b0));
    endfunction

    function automatic logic m_rdy1();
        return (m_phase == 0) && req1_valid && (!req0_valid || (m_ptr == 1'b1));
    endfunction

    task automatic model_step();
        logic [15:0]      full;
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   s;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 1'b0;
        end else begin
            case (m_phase)
                0: if (m_rdy0() || m_rdy1()) begin
                    m_id   = m_rdy1();
                    d      = m_id ? req1_data : req0_data;
                    s      = m_id ? req1_shamt : req0_shamt;
                    full   = {{(16-WIDTH){1'b0}}, d} << s;
                    m_data = full[WIDTH-1:0];
                    m_ovf  = |full[15:WIDTH];
                    m_ptr  = ~m_id;
                    m_left = int'(s);
                    m_phase = (s == '0) ? 2 : 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    endtask

    // Advance one clock; the model consumes the inputs seen at the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Clock until res_valid is seen or the budget runs out; returns edges used
    task automatic wait_result(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < budget);
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 0; req1_valid = 0; res_ready = 1'b1;
        req0_data = '0; req1_data = '0; req0_shamt = '0; req1_shamt = '0;
        tick(); tick();
        rst = 1'b0; #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_data !== 4'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if ({res_id, res_ovf} !== 2'b00) begin errors++; $display("FAIL reset_id_ovf: got %b want 00", {res_id, res_ovf}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_basic();
        req0_valid = 1; req0_data = 4'b0011; req0_shamt = 2'd2; res_ready = 1; #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL basic_accept: got %b want 01", {req1_ready, req0_ready}); end
        tick(); req0_valid = 0; #1;
        for (int c = 1; c <= 2; c++) begin
            checks++; if ({busy, res_valid} !== 2'b10) begin errors++; $display("FAIL basic_shift_T%0d: busy/valid got %b want 10", c, {busy, res_valid}); end
            tick();
        end
        checks++; if ({busy, res_valid} !== 2'b11) begin errors++; $display("FAIL basic_done: busy/valid got %b want 11", {busy, res_valid}); end
        checks++; if ({res_data, res_id, res_ovf} !== 6'b1100_0_0) begin errors++; $display("FAIL basic_result: got %b want 110000", {res_data, res_id, res_ovf}); end
        tick();
        checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL basic_idle: busy/valid got %b want 00", {busy, res_valid}); end
    endtask

    task automatic test_overflow_zero();
        int n;
        req1_valid = 1; req1_data = 4'b1011; req1_shamt = 2'd3; res_ready = 1; #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL ovf_accept: got %b want 10", {req1_ready, req0_ready}); end
        wait_result(20, n); req1_valid = 0;
        checks++; if (n !== 4) begin errors++; $display("FAIL ovf_latency: got %0d want 4", n); end
        checks++; if ({res_data, res_id, res_ovf} !== 6'b1000_1_1) begin errors++; $display("FAIL ovf_result: got %b want 100011", {res_data, res_id, res_ovf}); end
        tick();
        req0_valid = 1; req0_data = 4'b1010; req0_shamt = 2'd0; #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL zero_accept: got %b want 1", req0_ready); end
        wait_result(20, n); req0_valid = 0;
        checks++; if (n !== 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", n); end
        checks++; if ({res_data, res_id, res_ovf} !== 6'b1010_0_0) begin errors++; $display("FAIL zero_result: got %b want 101000", {res_data, res_id, res_ovf}); end
        tick();
    endtask

    task automatic test_arbitration();
        logic [WIDTH-1:0] d0, d1;
        rst = 1; req0_valid = 1; req1_valid = 1; res_ready = 1;
        req0_shamt = 2'd1; req1_shamt = 2'd1;
        tick(); rst = 0;
        for (int k = 0; k < 4; k++) begin
            d0 = WIDTH'($urandom); d1 = WIDTH'($urandom);
            req0_data = d0; req1_data = d1; #1;
            checks++; if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL arb_grant_%0d: got %b", k, {req1_ready, req0_ready}); end
            tick(); #1;
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL arb_ready_busy_%0d: got %b want 00", k, {req1_ready, req0_ready}); end
            tick();
            checks++; if ({res_valid, res_id} !== {1'b1, 1'(k % 2)}) begin errors++; $display("FAIL arb_res_id_%0d: got %b want %b", k, {res_valid, res_id}, {1'b1, 1'(k % 2)}); end
            checks++; if (res_data !== (((k % 2 == 0) ? d0 : d1) << 1)) begin errors++; $display("FAIL arb_res_data_%0d: got %h", k, res_data); end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure();
        int n;
        req0_valid = 1; req0_data = 4'b1110; req0_shamt = 2'd1; res_ready = 0; #1;
        tick(); req0_valid = 0; req1_valid = 1; req1_data = 4'b0001; req1_shamt = 2'd0;
        wait_result(20, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL bp_latency: got %0d want 1", n); end
        for (int c = 0; c < 6; c++) begin
            if (c == 5) res_ready = 1;
            #1;
            checks++; if ({res_valid, res_data, res_id, res_ovf} !== 7'b1_1100_0_1) begin errors++; $display("FAIL bp_hold_%0d: got %b want 1110001", c, {res_valid, res_data, res_id, res_ovf}); end
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready_%0d: got %b want 00", c, {req1_ready, req0_ready}); end
            tick();
        end
        #1;
        checks++; if ({busy, res_valid, req1_ready} !== 3'b001) begin errors++; $display("FAIL bp_idle: busy/valid/rdy1 got %b want 001", {busy, res_valid, req1_ready}); end
        req1_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        req0_valid = 1; req0_data = 4'b1111; req0_shamt = 2'd3; res_ready = 1; #1;
        tick(); req0_valid = 0; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_shift: busy got %b want 1", busy); end
        rst = 1; tick(); rst = 0; #1;
        checks++; if ({busy, res_valid, res_data, res_id, res_ovf, req0_ready, req1_ready} !== 10'd0) begin errors++; $display("FAIL rmid_outputs: got %b want 0", {busy, res_valid, res_data, res_id, res_ovf, req0_ready, req1_ready}); end
        req0_valid = 1; req1_valid = 1; req0_data = 4'b0001; req0_shamt = 2'd1;
        req1_data = 4'b0101; req1_shamt = 2'd1; #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rmid_ptr_reset: got %b want 01", {req1_ready, req0_ready}); end
        tick(); req0_valid = 0; req1_valid = 0;
        wait_result(20, n);
        checks++; if ({res_valid, res_data, res_id, res_ovf} !== 7'b1_0010_0_0) begin errors++; $display("FAIL rmid_next_result: got %b want 1001000", {res_valid, res_data, res_id, res_ovf}); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_data  = WIDTH'($urandom);
            req1_data  = WIDTH'($urandom);
            req0_shamt = SHW'($urandom);
            req1_shamt = SHW'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if ({req1_ready, req0_ready} !== {m_rdy1(), m_rdy0()}) begin errors++; $display("FAIL rand_ready c=%0d: got %b want %b", c, {req1_ready, req0_ready}, {m_rdy1(), m_rdy0()}); end
            checks++; if ({busy, res_valid} !== {m_phase != 0, m_phase == 2}) begin errors++; $display("FAIL rand_state c=%0d: busy/valid got %b want %b", c, {busy, res_valid}, {m_phase != 0, m_phase == 2}); end
            if (m_phase == 2) begin
                checks++; if ({res_data, res_id, res_ovf} !== {m_data, m_id, m_ovf}) begin errors++; $display("FAIL rand_result c=%0d: got %b want %b", c, {res_data, res_id, res_ovf}, {m_data, m_id, m_ovf}); end
            end else begin
                checks++; if ({res_data, res_id, res_ovf} !== '0) begin errors++; $display("FAIL rand_quiet c=%0d: got %b want 0", c, {res_data, res_id, res_ovf}); end
            end
            tick();
        end
        rst = 0; req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        m_phase = 0; m_left = 0; m_ptr = 1'b0;
        m_data = '0; m_id = 1'b0; m_ovf = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_overflow_zero();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_rr_sequencer
`default_nettype wire
